// File: rtl/seq_mult_sched_pkg.sv
// Shared types and helpers for the serial-multiplier scheduler.
package seq_mult_sched_pkg;

  localparam int N_DEF  = 4;
  localparam int P_DEF  = 2;
  localparam int MW_DEF = 16;
  localparam int BS_W   = $clog2(MW_DEF / P_DEF) + 1;
  localparam int ID_W   = $clog2(N_DEF);

  typedef enum logic [1:0] {IDLE, ISSUE, COLLECT, RESPOND} state_t;

  // A bitsize is usable when it is non-zero and fits the operand width.
  function automatic logic bitsize_legal(input int unsigned bs, input int unsigned max_steps);
    return (bs != 0) && (bs <= max_steps);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer.
module rr_arbiter #(
  parameter  int N    = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_i,
  input  logic            advance_i,
  output logic [N-1:0]    grant_o,
  output logic [ID_W-1:0] grant_id_o
);

  logic [ID_W-1:0] ptr_q, ptr_d;

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    int unsigned idx;
    grant_o    = '0;
    grant_id_o = '0;
    idx        = 0;
    for (int off = N - 1; off >= 0; off--) begin
      idx = (int'(ptr_q) + off) % N;
      if (req_i[idx]) begin
        grant_o      = '0;
        grant_o[idx] = 1'b1;
        grant_id_o   = ID_W'(idx);
      end
    end
  end

  assign ptr_d = (grant_id_o == ID_W'(N - 1)) ? '0 : grant_id_o + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            ptr_q <= '0;
    else if (advance_i) ptr_q <= ptr_d;
  end

endmodule

// File: rtl/seq_mult_sched.sv
// Shares one serial multiplier between N requesters, one operation in flight.
module seq_mult_sched #(
  parameter  int N         = 4,
  parameter  int P         = 2,
  parameter  int MAX_WIDTH = 16,
  parameter  int BS_W      = $clog2(MAX_WIDTH / P) + 1,
  localparam int ID_W      = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req_valid_i,
  output logic [N-1:0]           req_ready_o,
  input  logic [N*MAX_WIDTH-1:0] req_a_i,
  input  logic [N*MAX_WIDTH-1:0] req_b_i,
  input  logic [N*BS_W-1:0]      req_bitsize_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [ID_W-1:0]        rsp_id_o,
  output logic [2*MAX_WIDTH-1:0] rsp_prod_o,
  output logic                   rsp_err_o,
  output logic [MAX_WIDTH-1:0]   mul_a_o,
  output logic [MAX_WIDTH-1:0]   mul_b_o,
  output logic [BS_W-1:0]        mul_bitsize_o,
  output logic                   mul_valid_o,
  input  logic                   mul_ready_i,
  input  logic [P-1:0]           mul_p_i,
  input  logic                   mul_new_out_i,
  input  logic                   mul_valid_out_i,
  output logic                   mul_ready_out_o
);
  import seq_mult_sched_pkg::*;

  localparam int STEPS = MAX_WIDTH / P;
  localparam int CNT_W = BS_W + 1;

  state_t                 state_q, state_d;
  logic [MAX_WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [BS_W-1:0]        bs_q, bs_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic [2*MAX_WIDTH-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   err_q, err_d;

  logic [N-1:0]           grant;
  logic [ID_W-1:0]        grant_id;
  logic                   accept;
  logic [CNT_W-1:0]       exp_cnt;

  rr_arbiter #(.N(N)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_valid_i),
    .advance_i  (accept),
    .grant_o    (grant),
    .grant_id_o (grant_id)
  );

  // Ready is masked during reset so every output reads zero while rst is high.
  assign req_ready_o = (state_q == IDLE && !rst) ? grant : '0;
  assign accept      = |req_ready_o;
  assign exp_cnt     = {bs_q, 1'b0};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    bs_d    = bs_q;
    id_d    = id_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: if (accept) begin
        a_d    = req_a_i[grant_id*MAX_WIDTH +: MAX_WIDTH];
        b_d    = req_b_i[grant_id*MAX_WIDTH +: MAX_WIDTH];
        bs_d   = req_bitsize_i[grant_id*BS_W +: BS_W];
        id_d   = grant_id;
        prod_d = '0;
        cnt_d  = '0;
        if (bitsize_legal(32'(bs_d), 32'(STEPS))) begin
          err_d   = 1'b0;
          state_d = ISSUE;
        end else begin
          err_d   = 1'b1;
          state_d = RESPOND;
        end
      end
      ISSUE: if (mul_ready_i) state_d = COLLECT;
      COLLECT: begin
        // Surplus chunks are dropped but flagged; a coincident chunk counts toward the check.
        if (mul_new_out_i) begin
          if (cnt_q < exp_cnt) begin
            prod_d[int'(cnt_q)*P +: P] = mul_p_i;
            cnt_d = cnt_q + 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        if (mul_valid_out_i) begin
          if (cnt_d != exp_cnt) err_d = 1'b1;
          state_d = RESPOND;
        end
      end
      RESPOND: if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      bs_q    <= '0;
      id_q    <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      bs_q    <= bs_d;
      id_q    <= id_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign mul_a_o         = a_q;
  assign mul_b_o         = b_q;
  assign mul_bitsize_o   = bs_q;
  assign mul_valid_o     = (state_q == ISSUE);
  assign mul_ready_out_o = (state_q == COLLECT);
  assign rsp_valid_o     = (state_q == RESPOND);
  assign rsp_id_o        = id_q;
  assign rsp_prod_o      = prod_q;
  assign rsp_err_o       = err_q;

endmodule

// File: tb/tb_seq_mult_sched.sv
// Directed bench for seq_mult_sched with a behavioural serial multiplier.
module tb_seq_mult_sched;
  localparam int N   = 4;
  localparam int P   = 2;
  localparam int MW  = 16;
  localparam int BSW = seq_mult_sched_pkg::BS_W;
  localparam int IDW = seq_mult_sched_pkg::ID_W;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid, req_ready;
  logic [N*MW-1:0]   req_a, req_b;
  logic [N*BSW-1:0]  req_bs;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [IDW-1:0]    rsp_id;
  logic [2*MW-1:0]   rsp_prod;
  logic [MW-1:0]     mul_a, mul_b;
  logic [BSW-1:0]    mul_bs;
  logic              mul_valid, mul_ready, mul_new_out, mul_valid_out, mul_ready_out;
  logic [P-1:0]      mul_p;

  int n_cmp = 0;
  int n_err = 0;
  int mode  = 0;  // 0 normal, 1 one chunk short, 2 last chunk with done, 3 silent, 4 one extra chunk

  always #5 clk = ~clk;

  seq_mult_sched #(.N(N), .P(P), .MAX_WIDTH(MW)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b), .req_bitsize_i(req_bs),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_prod_o(rsp_prod), .rsp_err_o(rsp_err),
    .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_bitsize_o(mul_bs),
    .mul_valid_o(mul_valid), .mul_ready_i(mul_ready),
    .mul_p_i(mul_p), .mul_new_out_i(mul_new_out), .mul_valid_out_i(mul_valid_out),
    .mul_ready_out_o(mul_ready_out)
  );

  // Serial multiplier model: acts 1 time unit after each falling edge.
  initial begin
    logic [2*MW-1:0] mp;
    int nc;
    mul_p = '0; mul_new_out = 1'b0; mul_valid_out = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (!rst && mul_valid && mul_ready && mode != 3) begin
        mp = 32'(mul_a) * 32'(mul_b);
        nc = 2 * int'(mul_bs) - ((mode == 1) ? 1 : 0);
        for (int k = 0; k < nc + ((mode == 4) ? 1 : 0); k++) begin
          @(negedge clk); #1;
          mul_new_out = 1'b1;
          if (k < nc) mul_p = mp[k*P +: P];
          else        mul_p = 2'b11;
          mul_valid_out = (mode == 2 && k == nc - 1);
        end
        @(negedge clk); #1;
        mul_new_out = 1'b0; mul_p = '0;
        if (mode != 2) begin
          mul_valid_out = 1'b1;
          @(negedge clk); #1;
        end
        mul_valid_out = 1'b0;
      end
    end
  end

  task automatic set_req(input int i, input logic [MW-1:0] a, input logic [MW-1:0] b,
                         input logic [BSW-1:0] bs);
    req_a[i*MW +: MW]    = a;
    req_b[i*MW +: MW]    = b;
    req_bs[i*BSW +: BSW] = bs;
    req_valid[i]         = 1'b1;
  endtask

  task automatic wait_rsp(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (rsp_valid === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic rsp_hs();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; req_a = '1; req_b = '1; req_bs = '1;
    rsp_ready = 1'b0; mul_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_id !== '0) begin n_err++; $display("FAIL rst_rsp_id: got %0d want 0", rsp_id); end
    n_cmp++; if (rsp_prod !== '0) begin n_err++; $display("FAIL rst_rsp_prod: got %0h want 0", rsp_prod); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL rst_rsp_err: got %b want 0", rsp_err); end
    n_cmp++; if (mul_valid !== 1'b0) begin n_err++; $display("FAIL rst_mul_valid: got %b want 0", mul_valid); end
    n_cmp++; if (mul_ready_out !== 1'b0) begin n_err++; $display("FAIL rst_mul_ready_out: got %b want 0", mul_ready_out); end
    n_cmp++; if ({mul_a, mul_b, mul_bs} !== '0) begin n_err++; $display("FAIL rst_mul_ops: got %h %h %h want 0", mul_a, mul_b, mul_bs); end
    rst = 1'b0; req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    bit ok;
    int id;
    for (int i = 0; i < N; i++) set_req(i, MW'(i + 1), 16'd3, 4'd2);
    for (int k = 0; k < 5; k++) begin
      id = k % 4;
      wait_rsp(60, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL rr_timeout_%0d: rsp_valid got 0 want 1", k); end
      n_cmp++; if (rsp_id !== IDW'(id)) begin n_err++; $display("FAIL rr_id_%0d: got %0d want %0d", k, rsp_id, id); end
      n_cmp++; if (rsp_prod !== 32'(3 * (id + 1))) begin n_err++; $display("FAIL rr_prod_%0d: got %0d want %0d", k, rsp_prod, 3 * (id + 1)); end
      n_cmp++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL rr_err_%0d: got %b want 0", k, rsp_err); end
      if (k == 4) req_valid = '0;
      rsp_hs();
    end
  endtask

  task automatic test_single();
    bit ok;
    set_req(2, 16'd3, 16'd5, 4'd1);
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    n_cmp++; if (mul_valid !== 1'b1) begin n_err++; $display("FAIL single_mul_valid: got %b want 1", mul_valid); end
    n_cmp++; if ({mul_a, mul_b, mul_bs} !== {16'd3, 16'd5, 4'd1}) begin n_err++; $display("FAIL single_mul_ops: got %0d %0d %0d want 3 5 1", mul_a, mul_b, mul_bs); end
    n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL single_ready_busy: got %b want 0000", req_ready); end
    wait_rsp(40, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL single_timeout: rsp_valid got 0 want 1"); end
    n_cmp++; if (rsp_prod !== 32'd15) begin n_err++; $display("FAIL single_prod: got %0d want 15", rsp_prod); end
    n_cmp++; if (rsp_id !== 2'd2) begin n_err++; $display("FAIL single_id: got %0d want 2", rsp_id); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL single_err: got %b want 0", rsp_err); end
    rsp_hs();
  endtask

  task automatic test_rsp_hold();
    bit ok;
    set_req(0, 16'd7, 16'd9, 4'd2);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(40, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL hold_timeout: rsp_valid got 0 want 1"); end
    set_req(3, 16'd2, 16'd2, 4'd1);
    for (int c = 0; c < 10; c++) begin
      n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid_%0d: got %b want 1", c, rsp_valid); end
      n_cmp++; if (rsp_prod !== 32'd63 || rsp_id !== 2'd0 || rsp_err !== 1'b0) begin
        n_err++; $display("FAIL hold_rsp_%0d: got prod %0d id %0d err %b want 63 0 0", c, rsp_prod, rsp_id, rsp_err);
      end
      n_cmp++; if (req_ready !== 4'b0 || mul_valid !== 1'b0) begin
        n_err++; $display("FAIL hold_busy_%0d: got ready %b mul_valid %b want 0000 0", c, req_ready, mul_valid);
      end
      @(negedge clk);
    end
    rsp_hs();
    n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL hold_next_ready: got %b want 1000", req_ready); end
    @(negedge clk);
    req_valid = '0;
    wait_rsp(40, ok);
    n_cmp++; if (!ok || rsp_prod !== 32'd4 || rsp_id !== 2'd3) begin
      n_err++; $display("FAIL hold_next_rsp: got ok %b prod %0d id %0d want 1 4 3", ok, rsp_prod, rsp_id);
    end
    rsp_hs();
  endtask

  task automatic test_illegal();
    bit ok;
    logic [BSW-1:0] bad [2];
    bad[0] = 4'd0; bad[1] = 4'd9;
    for (int k = 0; k < 2; k++) begin
      set_req(k + 1, 16'd5, 16'd5, bad[k]);
      @(negedge clk);
      req_valid = '0;
      n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL illegal_valid_%0d: got %b want 1", k, rsp_valid); end
      n_cmp++; if (rsp_prod !== '0 || rsp_err !== 1'b1) begin n_err++; $display("FAIL illegal_rsp_%0d: got prod %0d err %b want 0 1", k, rsp_prod, rsp_err); end
      n_cmp++; if (rsp_id !== IDW'(k + 1)) begin n_err++; $display("FAIL illegal_id_%0d: got %0d want %0d", k, rsp_id, k + 1); end
      n_cmp++; if (mul_valid !== 1'b0) begin n_err++; $display("FAIL illegal_mul_valid_%0d: got %b want 0", k, mul_valid); end
      rsp_hs();
    end
    set_req(3, 16'hFFFF, 16'hFFFF, 4'd8);
    @(negedge clk);
    req_valid = '0;
    n_cmp++; if (mul_valid !== 1'b1) begin n_err++; $display("FAIL maxbs_mul_valid: got %b want 1", mul_valid); end
    wait_rsp(80, ok);
    n_cmp++; if (!ok || rsp_prod !== 32'hFFFE0001 || rsp_err !== 1'b0 || rsp_id !== 2'd3) begin
      n_err++; $display("FAIL maxbs_rsp: got ok %b prod %h err %b id %0d want 1 fffe0001 0 3", ok, rsp_prod, rsp_err, rsp_id);
    end
    rsp_hs();
  endtask

  task automatic test_issue_stall();
    bit ok;
    mul_ready = 1'b0;
    set_req(0, 16'd9, 16'd2, 4'd4);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_valid = '0;
      n_cmp++; if (mul_valid !== 1'b1 || mul_a !== 16'd9 || mul_b !== 16'd2) begin
        n_err++; $display("FAIL stall_hold_%0d: got valid %b a %0d b %0d want 1 9 2", c, mul_valid, mul_a, mul_b);
      end
    end
    mul_ready = 1'b1;
    wait_rsp(40, ok);
    n_cmp++; if (!ok || rsp_prod !== 32'd18 || rsp_err !== 1'b0) begin
      n_err++; $display("FAIL stall_rsp: got ok %b prod %0d err %b want 1 18 0", ok, rsp_prod, rsp_err);
    end
    rsp_hs();
  endtask

  task automatic test_chunk_errors();
    bit ok;
    int modes [3];
    logic [MW-1:0] av [3];
    logic [BSW-1:0] bv [3];
    logic [2*MW-1:0] ep [3];
    logic ee [3];
    modes = '{1, 2, 4};
    av = '{16'd5, 16'd15, 16'd3};
    bv = '{4'd2, 4'd2, 4'd1};
    ep = '{32'd30, 32'd225, 32'd9};
    ee = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      mode = modes[k];
      set_req(0, av[k], (k == 0) ? 16'd6 : av[k], bv[k]);
      @(negedge clk);
      req_valid = '0;
      wait_rsp(40, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL chunk_timeout_m%0d: rsp_valid got 0 want 1", mode); end
      n_cmp++; if (rsp_prod !== ep[k]) begin n_err++; $display("FAIL chunk_prod_m%0d: got %0d want %0d", mode, rsp_prod, ep[k]); end
      n_cmp++; if (rsp_err !== ee[k]) begin n_err++; $display("FAIL chunk_err_m%0d: got %b want %b", mode, rsp_err, ee[k]); end
      rsp_hs();
    end
    mode = 0;
  endtask

  task automatic test_reset_abort();
    bit ok;
    mode = 3;
    set_req(2, 16'd7, 16'd7, 4'd2);
    @(negedge clk);
    req_valid = '0;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (mul_ready_out === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++; if (!ok) begin n_err++; $display("FAIL abort_collect: mul_ready_out got 0 want 1"); end
    set_req(1, 16'd4, 16'd5, 4'd2);
    set_req(3, 16'd6, 16'd7, 4'd2);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (mul_ready_out !== 1'b0 || mul_valid !== 1'b0 || rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL abort_ctrl: got rdy_out %b mul_valid %b rsp_valid %b want 0 0 0", mul_ready_out, mul_valid, rsp_valid);
    end
    n_cmp++; if ({mul_a, mul_b, mul_bs, rsp_id, rsp_prod, rsp_err} !== '0) begin
      n_err++; $display("FAIL abort_data: got a %0d b %0d bs %0d id %0d prod %0d err %b want 0", mul_a, mul_b, mul_bs, rsp_id, rsp_prod, rsp_err);
    end
    n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL abort_req_ready: got %b want 0000", req_ready); end
    @(negedge clk);
    rst = 1'b0;
    mode = 0;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL abort_ptr: got %b want 0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    wait_rsp(40, ok);
    n_cmp++; if (!ok || rsp_prod !== 32'd20 || rsp_id !== 2'd1 || rsp_err !== 1'b0) begin
      n_err++; $display("FAIL abort_after: got ok %b prod %0d id %0d err %b want 1 20 1 0", ok, rsp_prod, rsp_id, rsp_err);
    end
    rsp_hs();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_rsp_hold();
    test_illegal();
    test_issue_stall();
    test_chunk_errors();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
